// File: rtl/corr_count_reader.sv
// Window sequencer for the correlator counter, plus snapshot and byte-frame readout.
// Optional build macro CORR_COUNT_READER_SEQNUM_EN prepends an 8-bit sequence byte to each frame.
module corr_count_reader #(
  parameter int DATA_W = 16,
  parameter int TIME_W = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cg,
  input  logic [$clog2(TIME_W+1)-1:0]  i_windowLengthExp,
  output logic [TIME_W-1:0]            o_t,
  output logic                         o_zeroCounts,
  input  logic [DATA_W-1:0]            i_countX,
  input  logic [DATA_W-1:0]            i_countY,
  input  logic [DATA_W-1:0]            i_countIsect,
  input  logic [DATA_W-1:0]            i_countSymdiff,
  output logic [7:0]                   o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_overrun,
  input  logic                         i_clearOverrun
);

  localparam int WLE_W = $clog2(TIME_W+1);
  localparam int BYTES = (DATA_W + 7) / 8;
  localparam int PAD_W = BYTES * 8;
`ifdef CORR_COUNT_READER_SEQNUM_EN
  localparam int FRAME_BYTES = 4 * BYTES + 1;
`else
  localparam int FRAME_BYTES = 4 * BYTES;
`endif
  localparam int FRAME_W = FRAME_BYTES * 8;
  localparam int IDX_W   = $clog2(FRAME_BYTES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [TIME_W-1:0]  t_q, t_d;
  logic               startPending_q, startPending_d;
  logic [WLE_W-1:0]   wle_q, wle_d;
  logic [0:0]         state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               overrun_q, overrun_d;
`ifdef CORR_COUNT_READER_SEQNUM_EN
  logic [7:0]         seq_q, seq_d;
`endif

  logic [WLE_W-1:0]   wleClamped;
  logic [WLE_W-1:0]   effWle;
  logic [TIME_W-1:0]  windowMax;
  logic               zeroCounts;
  logic               xfer;
  logic               lastByte;
  logic               load;
  logic               drop;
  logic [FRAME_W-1:0] snapshotFrame;

  // Until the first gated cycle of a window, the length tracks the input so the new window uses it.
  assign wleClamped = (i_windowLengthExp > WLE_W'(TIME_W)) ? WLE_W'(TIME_W) : i_windowLengthExp;
  assign effWle     = startPending_q ? wleClamped : wle_q;

  always_comb begin
    windowMax = '0;
    for (int i = 0; i < TIME_W; i++) begin
      windowMax[i] = (i < int'(effWle));
    end
  end

  assign zeroCounts = i_cg && i_rst_n && (t_q == windowMax);
  assign xfer       = (state_q == SEND) && i_ready;
  assign lastByte   = (idx_q == IDX_W'(FRAME_BYTES - 1));
  assign load       = zeroCounts && ((state_q == IDLE) || (xfer && lastByte));
  assign drop       = zeroCounts && !load;

`ifdef CORR_COUNT_READER_SEQNUM_EN
  assign snapshotFrame = {seq_q, PAD_W'(i_countX), PAD_W'(i_countY),
                          PAD_W'(i_countIsect), PAD_W'(i_countSymdiff)};
`else
  assign snapshotFrame = {PAD_W'(i_countX), PAD_W'(i_countY),
                          PAD_W'(i_countIsect), PAD_W'(i_countSymdiff)};
`endif

  always_comb begin
    t_d            = t_q;
    startPending_d = startPending_q;
    wle_d          = wle_q;
    if (startPending_q) begin
      wle_d = wleClamped;
    end
    if (i_cg) begin
      startPending_d = zeroCounts;
      t_d            = zeroCounts ? '0 : t_q + TIME_W'(1);
    end
  end

  // The frame is a shift register, so the idle buffer drains to zero and o_data reads 0 between frames.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    overrun_d = drop ? 1'b1 : (i_clearOverrun ? 1'b0 : overrun_q);
    if (load) begin
      frame_d = snapshotFrame;
      idx_d   = '0;
      state_d = SEND;
    end else if (xfer) begin
      frame_d = frame_q << 8;
      if (lastByte) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

`ifdef CORR_COUNT_READER_SEQNUM_EN
  assign seq_d = zeroCounts ? seq_q + 8'd1 : seq_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      t_q            <= '0;
      startPending_q <= 1'b1;
      wle_q          <= '0;
      state_q        <= IDLE;
      frame_q        <= '0;
      idx_q          <= '0;
      overrun_q      <= 1'b0;
`ifdef CORR_COUNT_READER_SEQNUM_EN
      seq_q          <= '0;
`endif
    end else begin
      t_q            <= t_d;
      startPending_q <= startPending_d;
      wle_q          <= wle_d;
      state_q        <= state_d;
      frame_q        <= frame_d;
      idx_q          <= idx_d;
      overrun_q      <= overrun_d;
`ifdef CORR_COUNT_READER_SEQNUM_EN
      seq_q          <= seq_d;
`endif
    end
  end

  assign o_t          = t_q;
  assign o_zeroCounts = zeroCounts;
  assign o_data       = frame_q[FRAME_W-1 -: 8];
  assign o_valid      = (state_q == SEND);
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_corr_count_reader.sv
// Randomised scoreboard bench for corr_count_reader against a window/frame reference model.
// Honours CORR_COUNT_READER_SEQNUM_EN the same way the design does.
module tb_corr_count_reader;

  localparam int DATA_W = 16;
  localparam int TIME_W = 8;
  localparam int WLE_W  = $clog2(TIME_W+1);
  localparam int BYTES  = (DATA_W + 7) / 8;
`ifdef CORR_COUNT_READER_SEQNUM_EN
  localparam int FRAME_BYTES = 4 * BYTES + 1;
  localparam bit SEQ_EN      = 1'b1;
`else
  localparam int FRAME_BYTES = 4 * BYTES;
  localparam bit SEQ_EN      = 1'b0;
`endif

  logic              i_clk;
  logic              i_rst_n;
  logic              i_cg;
  logic [WLE_W-1:0]  i_windowLengthExp;
  logic [TIME_W-1:0] o_t;
  logic              o_zeroCounts;
  logic [DATA_W-1:0] i_countX, i_countY, i_countIsect, i_countSymdiff;
  logic [7:0]        o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_overrun;
  logic              i_clearOverrun;

  corr_count_reader #(.DATA_W(DATA_W), .TIME_W(TIME_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cg(i_cg),
    .i_windowLengthExp(i_windowLengthExp), .o_t(o_t), .o_zeroCounts(o_zeroCounts),
    .i_countX(i_countX), .i_countY(i_countY), .i_countIsect(i_countIsect),
    .i_countSymdiff(i_countSymdiff), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_overrun(o_overrun), .i_clearOverrun(i_clearOverrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model: window position/length, bytes still owed for the current frame, expected byte stream.
  logic [7:0] expQ[$];
  int mT, mLen, remaining, mSeq;
  bit mStart, mOverrun;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mT = 0; mLen = 1; mStart = 1'b1; remaining = 0; mOverrun = 1'b0; mSeq = 0;
    expQ.delete();
  endtask

  task automatic pushCount(input logic [DATA_W-1:0] c);
    int unsigned v;
    v = 32'(c);
    for (int b = BYTES - 1; b >= 0; b--) expQ.push_back(8'(v >> (8 * b)));
  endtask

  task automatic applyStimulus(input bit cg, input int wle, input bit ready, input bit clr,
                               input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                               input logic [DATA_W-1:0] is, input logic [DATA_W-1:0] sd);
    int effLen;
    bit expZc, xferNow, dropped;
    @(negedge i_clk);
    i_rst_n = 1'b1; i_cg = cg; i_windowLengthExp = WLE_W'(wle); i_ready = ready;
    i_clearOverrun = clr; i_countX = x; i_countY = y; i_countIsect = is; i_countSymdiff = sd;
    #1;
    effLen = mStart ? (1 << ((wle > TIME_W) ? TIME_W : wle)) : mLen;
    expZc  = cg && (mT == effLen - 1);
    checkOutput("o_t", 32'(o_t), 32'(mT));
    checkOutput("o_zeroCounts", 32'(o_zeroCounts), 32'(expZc));
    checkOutput("o_valid", 32'(o_valid), 32'(remaining > 0));
    checkOutput("o_overrun", 32'(o_overrun), 32'(mOverrun));
    xferNow = (remaining > 0) && ready;
    dropped = 1'b0;
    if (cg) begin
      if (mStart) begin mLen = effLen; mStart = 1'b0; end
      if (expZc) begin mT = 0; mStart = 1'b1; end
      else mT++;
    end
    if (expZc && (remaining == 0 || (remaining == 1 && ready))) begin
      if (SEQ_EN) expQ.push_back(8'(mSeq));
      pushCount(x); pushCount(y); pushCount(is); pushCount(sd);
      remaining = FRAME_BYTES;
    end else begin
      if (expZc) dropped = 1'b1;
      if (xferNow) remaining--;
    end
    if (expZc) mSeq = (mSeq + 1) % 256;
    if (dropped) mOverrun = 1'b1;
    else if (clr) mOverrun = 1'b0;
  endtask

  task automatic doReset();
    @(negedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("reset o_t", 32'(o_t), 32'd0);
    checkOutput("reset o_zeroCounts", 32'(o_zeroCounts), 32'd0);
    checkOutput("reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("reset o_data", 32'(o_data), 32'd0);
    checkOutput("reset o_overrun", 32'(o_overrun), 32'd0);
    modelReset();
    repeat (2) @(negedge i_clk);
  endtask

  // Monitor: every presented byte must match the scoreboard head; it is consumed only on a transfer.
  always @(negedge i_clk) begin
    #2;
    if (i_rst_n && o_valid) begin
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL unexpected byte: got 0x%0h, expected no valid data at %0t", o_data, $time);
      end else begin
        checkOutput("o_data", 32'(o_data), 32'(expQ[0]));
        if (i_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int curWle;
    i_rst_n = 1'b0; i_cg = 1'b0; i_windowLengthExp = '0; i_ready = 1'b0; i_clearOverrun = 1'b0;
    i_countX = '0; i_countY = '0; i_countIsect = '0; i_countSymdiff = '0;
    modelReset();
    doReset();

    $display("[TB] wle=3 free-running frames");
    for (int i = 0; i < 30; i++)
      applyStimulus(1, 3, 1, 0, 16'h1234, 16'h00FF, 16'h0011, 16'h1200);

    $display("[TB] backpressure mid-frame");
    for (int i = 0; i < 30; i++)
      applyStimulus(1, 3, !(i >= 3 && i < 8), 0, 16'hA5C3, 16'h0F0F, 16'h8001, 16'h7FFE);
    applyStimulus(1, 3, 1, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

    $display("[TB] wle=2 overrun and clear");
    doReset();
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 2, 1, 0, 16'(i * 37), 16'(i * 91), 16'(i + 5), 16'hBEEF);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 2, 1, (i == 1), 16'h0102, 16'h0304, 16'h0506, 16'h0708);

    $display("[TB] window length change mid-window");
    doReset();
    for (int i = 0; i < 2; i++) applyStimulus(1, 3, 1, 0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    for (int i = 0; i < 50; i++) applyStimulus(1, 5, 1, 0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);

    $display("[TB] clock gate off, then reset mid-frame");
    for (int i = 0; i < 10; i++) applyStimulus(0, 5, 1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 40 && remaining == 0; i++)
      applyStimulus(1, 2, 1, 0, 16'hCAFE, 16'hF00D, 16'h1357, 16'h2468);
    applyStimulus(1, 2, 0, 0, 16'hCAFE, 16'hF00D, 16'h1357, 16'h2468);
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(0, 3, 1, 0, 16'h0, 16'h0, 16'h0, 16'h0);

    $display("[TB] randomised traffic");
    curWle = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) curWle = $urandom_range(0, 15);
      applyStimulus($urandom_range(0, 9) != 0, curWle, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom));
    end

    if (SEQ_EN) begin
      $display("[TB] sequence wrap over 260 windows");
      doReset();
      for (int i = 0; i < 260 * 16; i++)
        applyStimulus(1, 4, 1, 0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    for (int i = 0; i < 40; i++) applyStimulus(0, 3, 1, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
